// File: rtl/lsu_req_seq.sv
// Load/store request sequencer: one op in flight, req/gnt/rvalid handshake, lane build and load alignment.
// Optional build macro LSU_MISALIGN_TRAP_EN: misaligned ops raise lsu_err instead of being truncated.
module lsu_req_seq #(
   parameter int ADDR_W  = 14,
   parameter int TIMEOUT = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ex_valid,
   input  logic              mem_read,
   input  logic              mem_write,
   input  logic [2:0]        func3,
   input  logic [ADDR_W-1:0] mem_addr,
   input  logic [31:0]       store_data,
   input  logic [4:0]        rd_addr,
   output logic              stall,
   output logic              dmem_req,
   output logic              dmem_we,
   output logic [ADDR_W-3:0] dmem_addr,
   output logic [31:0]       dmem_wdata,
   output logic [3:0]        store_op,
   input  logic              dmem_gnt,
   input  logic              dmem_rvalid,
   input  logic [31:0]       dmem_rdata,
   output logic              wb_valid,
   output logic [4:0]        wb_rd,
   output logic [31:0]       wb_data,
   output logic              lsu_err
);

   localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

   state_t        state;
   logic [TW-1:0] timer;
   logic [2:0]    op_f3;
   logic [1:0]    op_off;
   logic [4:0]    op_rd;
   logic          start;
   logic          trap;

   // func3[1:0]: 00 byte, 01 half, anything else is a word access.
   function automatic logic [3:0] lanes(input logic [2:0] f, input logic [1:0] off);
      case (f[1:0])
         2'b00:   lanes = 4'b0001 << off;
         2'b01:   lanes = 4'b0011 << {off[1], 1'b0};
         default: lanes = 4'b1111;
      endcase
   endfunction

   function automatic logic [31:0] wdata(input logic [2:0] f, input logic [31:0] sd);
      case (f[1:0])
         2'b00:   wdata = {4{sd[7:0]}};
         2'b01:   wdata = {2{sd[15:0]}};
         default: wdata = sd;
      endcase
   endfunction

   function automatic logic [31:0] extract(input logic [2:0] f, input logic [1:0] off,
                                           input logic [31:0] rd);
      logic [31:0] sb;
      logic [31:0] sh;
      sb = rd >> {off, 3'b000};
      sh = rd >> {off[1], 4'b0000};
      case (f[1:0])
         2'b00:   extract = f[2] ? {24'b0, sb[7:0]}  : {{24{sb[7]}}, sb[7:0]};
         2'b01:   extract = f[2] ? {16'b0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
         default: extract = rd;
      endcase
   endfunction

`ifdef LSU_MISALIGN_TRAP_EN
   function automatic logic misaligned(input logic [2:0] f, input logic [1:0] off);
      case (f[1:0])
         2'b00:   misaligned = 1'b0;
         2'b01:   misaligned = off[0];
         default: misaligned = (off != 2'b00);
      endcase
   endfunction

   assign trap = misaligned(func3, mem_addr[1:0]);
`else
   assign trap = 1'b0;
`endif

   assign start = ex_valid & (mem_read | mem_write);
   // Combinational so the execute stage holds from the very cycle the op is presented.
   assign stall = (state != IDLE) | start;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         timer      <= '0;
         op_f3      <= '0;
         op_off     <= '0;
         op_rd      <= '0;
         dmem_req   <= 1'b0;
         dmem_we    <= 1'b0;
         dmem_addr  <= '0;
         dmem_wdata <= '0;
         store_op   <= '0;
         wb_valid   <= 1'b0;
         wb_rd      <= '0;
         wb_data    <= '0;
         lsu_err    <= 1'b0;
      end else begin
         wb_valid <= 1'b0;
         lsu_err  <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  op_f3  <= func3;
                  op_off <= mem_addr[1:0];
                  op_rd  <= rd_addr;
                  timer  <= '0;
                  if (trap) begin
                     lsu_err <= 1'b1;
                  end else begin
                     state      <= REQ;
                     dmem_req   <= 1'b1;
                     // A simultaneous read+write request is handled as a load.
                     dmem_we    <= mem_write & ~mem_read;
                     dmem_addr  <= mem_addr[ADDR_W-1:2];
                     dmem_wdata <= wdata(func3, store_data);
                     store_op   <= (mem_write & ~mem_read) ? lanes(func3, mem_addr[1:0]) : 4'b0000;
                  end
               end
            end
            REQ: begin
               if (dmem_gnt) begin
                  dmem_req <= 1'b0;
                  store_op <= 4'b0000;
                  timer    <= '0;
                  if (dmem_we) begin
                     dmem_we <= 1'b0;
                     state   <= IDLE;
                  end else begin
                     state <= WAIT;
                  end
               end else if (timer == TMAX) begin
                  dmem_req <= 1'b0;
                  dmem_we  <= 1'b0;
                  store_op <= 4'b0000;
                  lsu_err  <= 1'b1;
                  state    <= IDLE;
               end else begin
                  timer <= timer + 1'b1;
               end
            end
            WAIT: begin
               if (dmem_rvalid) begin
                  wb_valid <= 1'b1;
                  wb_rd    <= op_rd;
                  wb_data  <= extract(op_f3, op_off, dmem_rdata);
                  state    <= IDLE;
               end else if (timer == TMAX) begin
                  lsu_err <= 1'b1;
                  state   <= IDLE;
               end else begin
                  timer <= timer + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_lsu_req_seq.sv
// Self-checking bench for lsu_req_seq: directed vectors plus randomized ops against an arithmetic reference model.
module tb_lsu_req_seq;

   localparam int ADDR_W  = 14;
   localparam int TIMEOUT = 16;

   logic              clk = 1'b0;
   logic              rst;
   logic              ex_valid, mem_read, mem_write;
   logic [2:0]        func3;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       store_data;
   logic [4:0]        rd_addr;
   logic              stall, dmem_req, dmem_we;
   logic [ADDR_W-3:0] dmem_addr;
   logic [31:0]       dmem_wdata;
   logic [3:0]        store_op;
   logic              dmem_gnt, dmem_rvalid;
   logic [31:0]       dmem_rdata;
   logic              wb_valid;
   logic [4:0]        wb_rd;
   logic [31:0]       wb_data;
   logic              lsu_err;

   int n_tot  = 0;
   int n_pass = 0;

   lsu_req_seq #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst(rst), .ex_valid(ex_valid), .mem_read(mem_read), .mem_write(mem_write),
      .func3(func3), .mem_addr(mem_addr), .store_data(store_data), .rd_addr(rd_addr),
      .stall(stall), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
      .dmem_wdata(dmem_wdata), .store_op(store_op), .dmem_gnt(dmem_gnt),
      .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata), .wb_valid(wb_valid),
      .wb_rd(wb_rd), .wb_data(wb_data), .lsu_err(lsu_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tot++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      n_tot++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
   endtask

   // Reference model: access size in bytes, offset after dropping misaligned low bits.
   function automatic int acc_size(input logic [2:0] f);
      if (f == 3'd0 || f == 3'd4) return 1;
      if (f == 3'd1 || f == 3'd5) return 2;
      return 4;
   endfunction

   function automatic int al_off(input logic [ADDR_W-1:0] a, input int s);
      int o;
      o = int'(a) % 4;
      return o - (o % s);
   endfunction

   function automatic logic [31:0] m_wdata(input int s, input logic [31:0] sd);
      if (s == 1) return (sd & 32'hFF) * 32'h0101_0101;
      if (s == 2) return (sd & 32'hFFFF) * 32'h0001_0001;
      return sd;
   endfunction

   function automatic logic [31:0] m_load(input logic [2:0] f, input int off, input logic [31:0] rd);
      int s;
      logic [31:0] mask, v;
      s    = acc_size(f);
      mask = (s == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * s)) - 32'd1);
      v    = (rd >> (8 * off)) & mask;
      if (!f[2] && s < 4 && v[8*s-1]) v = v | ~mask;
      return v;
   endfunction

   function automatic bit m_misaligned(input logic [ADDR_W-1:0] a, input int s);
      return (int'(a) % s) != 0;
   endfunction

   // Drives one op and plays the memory; g/r are grant/rvalid delays in cycles, negative = never.
   task automatic run_op(input bit ld, input bit st, input logic [2:0] f3, input logic [ADDR_W-1:0] addr,
                         input logic [31:0] sd, input logic [4:0] rd, input int g, input int r,
                         input logic [31:0] rdat, output logic [ADDR_W-3:0] o_addr,
                         output logic [3:0] o_so, output logic [31:0] o_wd, output logic [31:0] o_wb);
      bit is_st, granted, got;
      int s, off, cyc;
      logic [31:0] exp_wb;
      is_st  = st && !ld;
      s      = acc_size(f3);
      off    = al_off(addr, s);
      exp_wb = m_load(f3, off, rdat);
      o_addr = '0; o_so = '0; o_wd = '0; o_wb = '0;
      @(posedge clk); #1;
      ex_valid = 1'b1; mem_read = ld; mem_write = st; func3 = f3;
      mem_addr = addr; store_data = sd; rd_addr = rd;
      @(negedge clk);
      chk1("stall_accept", stall, 1'b1);
      chk1("req_accept", dmem_req, 1'b0);
      @(posedge clk); #1;
      ex_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
      if (m_misaligned(addr, s)) begin
         @(negedge clk);
         chk1("trap_err", lsu_err, 1'b1);
         chk1("trap_req", dmem_req, 1'b0);
         chk1("trap_stall", stall, 1'b0);
         @(posedge clk); #1;
         @(negedge clk);
         chk1("trap_err_pulse", lsu_err, 1'b0);
         return;
      end
`endif
      cyc = 0; granted = 0;
      while (!granted && cyc < TIMEOUT) begin
         if (g >= 0 && cyc == g) dmem_gnt = 1'b1;
         @(negedge clk);
         if (cyc == 0) begin
            o_addr = dmem_addr; o_so = store_op; o_wd = dmem_wdata;
            chk("addr", 32'(dmem_addr), 32'(addr >> 2));
            chk1("we", dmem_we, is_st);
            chk("store_op", 32'(store_op), is_st ? 32'(((1 << s) - 1) << off) : 32'd0);
            if (is_st) chk("wdata", dmem_wdata, m_wdata(s, sd));
         end
         chk1("req_hold", dmem_req, 1'b1);
         chk1("stall_req", stall, 1'b1);
         @(posedge clk); #1;
         granted = dmem_gnt; dmem_gnt = 1'b0; cyc++;
      end
      if (!granted) begin
         @(negedge clk);
         chk1("gnt_timeout_err", lsu_err, 1'b1);
         chk1("gnt_timeout_req", dmem_req, 1'b0);
         chk1("gnt_timeout_stall", stall, 1'b0);
         chk1("gnt_timeout_wb", wb_valid, 1'b0);
      end else if (is_st) begin
         @(negedge clk);
         chk1("st_done_req", dmem_req, 1'b0);
         chk1("st_done_stall", stall, 1'b0);
         chk("st_done_so", 32'(store_op), 32'd0);
         chk1("st_done_wb", wb_valid, 1'b0);
      end else begin
         cyc = 0; got = 0;
         while (!got && cyc < TIMEOUT) begin
            if (r >= 0 && cyc == r) begin dmem_rvalid = 1'b1; dmem_rdata = rdat; end
            @(negedge clk);
            chk1("wait_req", dmem_req, 1'b0);
            chk1("wait_stall", stall, 1'b1);
            chk1("wait_wb", wb_valid, 1'b0);
            @(posedge clk); #1;
            got = dmem_rvalid; dmem_rvalid = 1'b0; dmem_rdata = $urandom; cyc++;
         end
         @(negedge clk);
         o_wb = wb_data;
         chk1("ld_wb_valid", wb_valid, got);
         chk1("ld_err", lsu_err, !got);
         chk1("ld_stall", stall, 1'b0);
         if (got) begin
            chk("wb_rd", 32'(wb_rd), 32'(rd));
            chk("wb_data", wb_data, exp_wb);
         end
      end
      @(posedge clk); #1;
      @(negedge clk);
      chk1("wb_pulse", wb_valid, 1'b0);
      chk1("err_pulse", lsu_err, 1'b0);
   endtask

   initial begin
      logic [ADDR_W-3:0] oa;
      logic [3:0]        os;
      logic [31:0]       ow, ob;
      logic [2:0]        f3;
      bit                ld, st;
      rst = 1'b1; ex_valid = 0; mem_read = 0; mem_write = 0; func3 = '0; mem_addr = '0;
      store_data = '0; rd_addr = '0; dmem_gnt = 0; dmem_rvalid = 0; dmem_rdata = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk1("rst_stall", stall, 1'b0);
      chk1("rst_req", dmem_req, 1'b0);
      chk1("rst_we", dmem_we, 1'b0);
      chk("rst_so", 32'(store_op), 32'd0);
      chk("rst_addr", 32'(dmem_addr), 32'd0);
      chk("rst_wdata", dmem_wdata, 32'd0);
      chk1("rst_wb_valid", wb_valid, 1'b0);
      chk("rst_wb_rd", 32'(wb_rd), 32'd0);
      chk("rst_wb_data", wb_data, 32'd0);
      chk1("rst_err", lsu_err, 1'b0);
      @(posedge clk); #1 rst = 1'b0;

      // Directed vectors.
      run_op(0, 1, 3'b010, 14'h0104, 32'hDEADBEEF, 5'd0, 0, 0, 32'h0, oa, os, ow, ob);
      chk("sw_addr", 32'(oa), 32'h041);
      chk("sw_so", 32'(os), 32'hF);
      chk("sw_wdata", ow, 32'hDEADBEEF);
      run_op(0, 1, 3'b000, 14'h0003, 32'h000000A5, 5'd0, 1, 0, 32'h0, oa, os, ow, ob);
      chk("sb_so", 32'(os), 32'h8);
      chk("sb_wdata", ow, 32'hA5A5A5A5);
      run_op(1, 0, 3'b000, 14'h0002, 32'h0, 5'd5, 0, 0, 32'h00800000, oa, os, ow, ob);
      chk("lb_data", ob, 32'hFFFFFF80);
      run_op(1, 0, 3'b100, 14'h0002, 32'h0, 5'd5, 0, 0, 32'h00800000, oa, os, ow, ob);
      chk("lbu_data", ob, 32'h00000080);
      run_op(1, 0, 3'b001, 14'h0002, 32'h0, 5'd9, 2, 1, 32'h80011234, oa, os, ow, ob);
      chk("lh_data", ob, 32'hFFFF8001);
      run_op(1, 0, 3'b101, 14'h0002, 32'h0, 5'd9, 0, 3, 32'h80011234, oa, os, ow, ob);
      chk("lhu_data", ob, 32'h00008001);
      run_op(1, 1, 3'b010, 14'h0010, 32'h12345678, 5'd7, 0, 0, 32'hCAFEF00D, oa, os, ow, ob);
      chk("rw_as_load", ob, 32'hCAFEF00D);
      run_op(0, 1, 3'b010, 14'h0200, 32'h1, 5'd0, -1, 0, 32'h0, oa, os, ow, ob);
      run_op(1, 0, 3'b010, 14'h0200, 32'h0, 5'd3, 0, -1, 32'h0, oa, os, ow, ob);

      // Reset while waiting for read data: the late rvalid must not produce a writeback.
      @(posedge clk); #1;
      ex_valid = 1; mem_read = 1; func3 = 3'b010; mem_addr = 14'h0040; rd_addr = 5'd4;
      @(posedge clk); #1;
      ex_valid = 0; mem_read = 0; dmem_gnt = 1;
      @(posedge clk); #1;
      dmem_gnt = 0; rst = 1;
      @(posedge clk); #1;
      rst = 0; dmem_rvalid = 1; dmem_rdata = 32'h55AA55AA;
      @(negedge clk);
      chk1("rst_wait_stall", stall, 1'b0);
      @(posedge clk); #1 dmem_rvalid = 0;
      @(negedge clk);
      chk1("rst_wait_wb", wb_valid, 1'b0);
      chk1("rst_wait_req", dmem_req, 1'b0);

`ifdef LSU_MISALIGN_TRAP_EN
      run_op(1, 0, 3'b010, 14'h0001, 32'h0, 5'd1, 0, 0, 32'h0, oa, os, ow, ob);
`endif

      // Randomized ops checked against the reference model.
      for (int i = 0; i < 60; i++) begin
         ld = ($urandom_range(0, 1) == 1);
         st = !ld || ($urandom_range(0, 7) == 0);
         f3 = 3'($urandom_range(0, 7));
         if (!ld && (f3 == 3'd4 || f3 == 3'd5)) f3 = 3'b010;
         run_op(ld, st, f3, 14'($urandom_range(0, 16383)), $urandom, 5'($urandom_range(0, 31)),
                $urandom_range(0, 3), $urandom_range(0, 3), $urandom, oa, os, ow, ob);
      end

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
